// File: rtl/pe_pkg.sv
// Shared types and elaboration helpers for the systolic-array processing elements.
package pe_pkg;

  typedef enum logic {
    PE_PASS  = 1'b0,
    PE_ACCUM = 1'b1
  } pe_mode_e;

  // The accumulator must hold a full-width product without truncation.
  function automatic bit acc_width_ok(int unsigned acc_width, int unsigned reg_width);
    return acc_width >= 2 * reg_width;
  endfunction

endpackage

// File: rtl/pe_lane.sv
// One MAC lane: product, local accumulator and registered c_ab for a vec_mac_pe.
(* use_dsp = "no" *)
module pe_lane
  import pe_pkg::*;
#(
  parameter int unsigned REG_WIDTH = 16,
  parameter int unsigned ACC_WIDTH = 32,
  parameter int unsigned SIGNED    = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mode,
  input  logic                 valid,
  input  logic                 drain,
  input  logic                 c_valid_in,
  input  logic [REG_WIDTH-1:0] a,
  input  logic [REG_WIDTH-1:0] b,
  input  logic [ACC_WIDTH-1:0] c_in,
  output logic [ACC_WIDTH-1:0] c_ab
);

  logic [ACC_WIDTH-1:0] prod;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [ACC_WIDTH-1:0] c_ab_q, c_ab_d;

  if (SIGNED != 0) begin : gen_signed
    logic signed [2*REG_WIDTH-1:0] prod_s;
    assign prod_s = $signed({{REG_WIDTH{a[REG_WIDTH-1]}}, a}) *
                    $signed({{REG_WIDTH{b[REG_WIDTH-1]}}, b});
    assign prod   = ACC_WIDTH'(prod_s);
  end else begin : gen_unsigned
    logic [2*REG_WIDTH-1:0] prod_u;
    assign prod_u = {{REG_WIDTH{1'b0}}, a} * {{REG_WIDTH{1'b0}}, b};
    assign prod   = ACC_WIDTH'(prod_u);
  end

  always_comb begin
    acc_d  = acc_q;
    c_ab_d = c_ab_q;
    if (mode == PE_ACCUM) begin
      if (drain) begin
        // A beat arriving with the drain is folded into the result, not kept.
        c_ab_d = valid ? (acc_q + prod) : acc_q;
        acc_d  = '0;
      end else begin
        if (c_valid_in) c_ab_d = c_in;
        if (valid)      acc_d  = acc_q + prod;
      end
    end else if (valid) begin
      c_ab_d = prod + c_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q  <= '0;
      c_ab_q <= '0;
    end else begin
      acc_q  <= acc_d;
      c_ab_q <= c_ab_d;
    end
  end

  assign c_ab = c_ab_q;

endmodule

// File: rtl/vec_mac_pe.sv
// Vector MAC processing element: VECTOR lanes sharing operand forwarding and drain control.
(* use_dsp = "no" *)
module vec_mac_pe
  import pe_pkg::*;
#(
  parameter int unsigned REG_WIDTH = 16,
  parameter int unsigned VECTOR    = 2,
  parameter int unsigned ACC_WIDTH = 32,
  parameter int unsigned SIGNED    = 0
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               mode,
  input  logic                               valid_n_1,
  input  logic [VECTOR-1:0][REG_WIDTH-1:0]   a_n_1,
  input  logic [REG_WIDTH-1:0]               b_n_1,
  input  logic [VECTOR-1:0][ACC_WIDTH-1:0]   c_n_1,
  input  logic                               c_valid_n_1,
  input  logic                               drain_n_1,
  output logic [VECTOR-1:0][REG_WIDTH-1:0]   a_n,
  output logic [REG_WIDTH-1:0]               b_n,
  output logic                               valid_n,
  output logic                               drain_n,
  output logic [VECTOR-1:0][ACC_WIDTH-1:0]   c_ab,
  output logic                               c_valid,
  output logic                               collide
);

  if (!acc_width_ok(ACC_WIDTH, REG_WIDTH)) begin : gen_bad_width
    $error("vec_mac_pe: ACC_WIDTH must be at least 2*REG_WIDTH");
  end

  logic [VECTOR-1:0][REG_WIDTH-1:0] a_q;
  logic [REG_WIDTH-1:0]             b_q;
  logic                             valid_q, drain_q, c_valid_q, collide_q;
  logic                             c_valid_d, collide_d;

  always_comb begin
    c_valid_d = valid_n_1;
    collide_d = 1'b0;
    if (mode == PE_ACCUM) begin
      c_valid_d = drain_n_1 | c_valid_n_1;
      // Upstream result is lost when our own drain wins the output register.
      collide_d = drain_n_1 & c_valid_n_1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q       <= '0;
      b_q       <= '0;
      valid_q   <= 1'b0;
      drain_q   <= 1'b0;
      c_valid_q <= 1'b0;
      collide_q <= 1'b0;
    end else begin
      a_q       <= a_n_1;
      b_q       <= b_n_1;
      valid_q   <= valid_n_1;
      drain_q   <= drain_n_1;
      c_valid_q <= c_valid_d;
      collide_q <= collide_d;
    end
  end

  for (genvar i = 0; i < VECTOR; i++) begin : gen_lane
    pe_lane #(
      .REG_WIDTH(REG_WIDTH),
      .ACC_WIDTH(ACC_WIDTH),
      .SIGNED   (SIGNED)
    ) u_lane (
      .clk       (clk),
      .rst       (rst),
      .mode      (mode),
      .valid     (valid_n_1),
      .drain     (drain_n_1),
      .c_valid_in(c_valid_n_1),
      .a         (a_n_1[i]),
      .b         (b_n_1),
      .c_in      (c_n_1[i]),
      .c_ab      (c_ab[i])
    );
  end

  assign a_n     = a_q;
  assign b_n     = b_q;
  assign valid_n = valid_q;
  assign drain_n = drain_q;
  assign c_valid = c_valid_q;
  assign collide = collide_q;

endmodule

// File: tb/tb_vec_mac_pe.sv
// Self-checking bench for vec_mac_pe: directed table, signed corner cases, randomized model check.
module tb_vec_mac_pe;

  localparam int unsigned RW = 16;
  localparam int unsigned V  = 2;
  localparam int unsigned AW = 32;
  localparam int unsigned SRW = 8;
  localparam int unsigned SAW = 16;

  logic clk;
  int   tests, fails;

  // Unsigned default instance
  logic                  rst, mode, valid, cv, drain;
  logic [V-1:0][RW-1:0]  a;
  logic [RW-1:0]         b;
  logic [V-1:0][AW-1:0]  c;
  logic [V-1:0][RW-1:0]  a_n;
  logic [RW-1:0]         b_n;
  logic                  valid_n, drain_n, c_valid, collide;
  logic [V-1:0][AW-1:0]  c_ab;

  // Signed narrow instance
  logic                   s_rst, s_mode, s_valid, s_cv, s_drain;
  logic [V-1:0][SRW-1:0]  s_a;
  logic [SRW-1:0]         s_b;
  logic [V-1:0][SAW-1:0]  s_c;
  logic [V-1:0][SRW-1:0]  s_a_n;
  logic [SRW-1:0]         s_b_n;
  logic                   s_valid_n, s_drain_n, s_c_valid, s_collide;
  logic [V-1:0][SAW-1:0]  s_c_ab;

  vec_mac_pe #(.REG_WIDTH(RW), .VECTOR(V), .ACC_WIDTH(AW), .SIGNED(0)) u_dut (
    .clk(clk), .rst(rst), .mode(mode), .valid_n_1(valid), .a_n_1(a), .b_n_1(b),
    .c_n_1(c), .c_valid_n_1(cv), .drain_n_1(drain), .a_n(a_n), .b_n(b_n),
    .valid_n(valid_n), .drain_n(drain_n), .c_ab(c_ab), .c_valid(c_valid), .collide(collide)
  );

  vec_mac_pe #(.REG_WIDTH(SRW), .VECTOR(V), .ACC_WIDTH(SAW), .SIGNED(1)) u_dut_s (
    .clk(clk), .rst(s_rst), .mode(s_mode), .valid_n_1(s_valid), .a_n_1(s_a), .b_n_1(s_b),
    .c_n_1(s_c), .c_valid_n_1(s_cv), .drain_n_1(s_drain), .a_n(s_a_n), .b_n(s_b_n),
    .valid_n(s_valid_n), .drain_n(s_drain_n), .c_ab(s_c_ab), .c_valid(s_c_valid),
    .collide(s_collide)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  typedef struct {
    logic        mode, valid, cv, drain;
    logic [15:0] a0, a1, b;
    logic [31:0] c0, c1;
    logic [31:0] e0, e1;
    logic        ev, ecol;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic m, input logic v, input logic cvi, input logic d,
                     input logic [15:0] a0, input logic [15:0] a1, input logic [15:0] bi,
                     input logic [31:0] c0, input logic [31:0] c1,
                     input logic [31:0] e0, input logic [31:0] e1,
                     input logic ev, input logic ecol);
    vec_t r;
    r.mode = m; r.valid = v; r.cv = cvi; r.drain = d;
    r.a0 = a0; r.a1 = a1; r.b = bi; r.c0 = c0; r.c1 = c1;
    r.e0 = e0; r.e1 = e1; r.ev = ev; r.ecol = ecol;
    tbl.push_back(r);
  endtask

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model state for the randomized phase
  logic [31:0] macc [V];
  logic [31:0] mc   [V];
  logic        mcv, mcol;
  logic [49:0] mfwd;

  task automatic model_step();
    logic [31:0] p;
    if (rst) begin
      for (int l = 0; l < V; l++) begin
        macc[l] = '0;
        mc[l]   = '0;
      end
      mcv = 0; mcol = 0; mfwd = '0;
    end else begin
      mfwd = {a, b, valid, drain};
      if (mode == 1'b0) begin
        for (int l = 0; l < V; l++) begin
          p = 32'(a[l]) * 32'(b);
          if (valid) mc[l] = p + c[l];
        end
        mcv = valid; mcol = 0;
      end else if (drain) begin
        for (int l = 0; l < V; l++) begin
          p = 32'(a[l]) * 32'(b);
          mc[l]   = macc[l] + (valid ? p : 32'd0);
          macc[l] = '0;
        end
        mcv = 1; mcol = cv;
      end else begin
        for (int l = 0; l < V; l++) begin
          p = 32'(a[l]) * 32'(b);
          if (cv)    mc[l]   = c[l];
          if (valid) macc[l] = macc[l] + p;
        end
        mcv = cv; mcol = 0;
      end
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;

    // Reset with busy inputs: they must be ignored
    rst = 1; mode = 1; valid = 1; cv = 1; drain = 1;
    a[0] = 16'h1234; a[1] = 16'h5678; b = 16'h9abc; c[0] = 32'h11; c[1] = 32'h22;
    s_rst = 1; s_mode = 0; s_valid = 1; s_cv = 0; s_drain = 0;
    s_a = '0; s_b = 8'h05; s_c = '0;
    tick();
    check("reset outputs", {c_ab, c_valid, a_n, b_n, valid_n, drain_n, collide}, 128'd0);
    check("reset outputs signed",
          {s_c_ab, s_c_valid, s_a_n, s_b_n, s_valid_n, s_drain_n, s_collide}, 128'd0);
    rst = 0; s_rst = 0; s_valid = 0;

    // mode, valid, cv, drain, a0, a1, b, c0, c1 -> c_ab0, c_ab1, c_valid, collide
    add(0, 1, 0, 0, 3, 5, 7, 10, 20,             31, 55, 1, 0);
    add(0, 0, 0, 0, 9, 9, 9, 1, 1,               31, 55, 0, 0);
    add(1, 1, 0, 0, 1, 2, 3, 0, 0,               31, 55, 0, 0);
    add(1, 1, 0, 0, 1, 2, 3, 0, 0,               31, 55, 0, 0);
    add(1, 1, 0, 0, 1, 2, 3, 0, 0,               31, 55, 0, 0);
    add(1, 1, 0, 0, 1, 2, 3, 0, 0,               31, 55, 0, 0);
    add(1, 0, 0, 1, 0, 0, 0, 0, 0,               12, 24, 1, 0);
    add(1, 0, 0, 1, 0, 0, 0, 0, 0,               0, 0, 1, 0);
    add(1, 1, 0, 0, 5, 5, 1, 0, 0,               0, 0, 0, 0);
    add(1, 1, 0, 1, 2, 2, 2, 0, 0,               9, 9, 1, 0);
    add(1, 0, 0, 1, 0, 0, 0, 0, 0,               0, 0, 1, 0);
    add(1, 0, 1, 0, 0, 0, 0, 100, 200,           100, 200, 1, 0);
    add(1, 1, 0, 0, 1, 1, 1, 0, 0,               100, 200, 0, 0);
    add(1, 0, 1, 1, 0, 0, 0, 100, 200,           1, 1, 1, 1);
    add(1, 0, 0, 0, 0, 0, 0, 0, 0,               1, 1, 0, 0);
    add(1, 1, 0, 0, 2, 3, 1, 0, 0,               1, 1, 0, 0);
    add(0, 1, 0, 0, 1, 1, 1, 5, 6,               6, 7, 1, 0);
    add(1, 0, 0, 1, 0, 0, 0, 0, 0,               2, 3, 1, 0);
    add(1, 1, 0, 0, 16'hffff, 16'hffff, 16'hffff, 0, 0, 2, 3, 0, 0);
    add(1, 1, 0, 0, 16'hffff, 16'hffff, 16'hffff, 0, 0, 2, 3, 0, 0);
    add(1, 0, 0, 1, 0, 0, 0, 0, 0,               32'hfffc0002, 32'hfffc0002, 1, 0);
    add(0, 1, 0, 0, 16'hffff, 16'hffff, 16'hffff, 32'h1ffff, 32'h1ffff, 0, 0, 1, 0);
    add(0, 0, 1, 1, 7, 7, 7, 3, 3,               0, 0, 0, 0);

    foreach (tbl[i]) begin
      mode = tbl[i].mode; valid = tbl[i].valid; cv = tbl[i].cv; drain = tbl[i].drain;
      a[0] = tbl[i].a0; a[1] = tbl[i].a1; b = tbl[i].b;
      c[0] = tbl[i].c0; c[1] = tbl[i].c1;
      tick();
      check($sformatf("row%0d c_ab", i), c_ab, {tbl[i].e1, tbl[i].e0});
      check($sformatf("row%0d c_valid", i), c_valid, tbl[i].ev);
      check($sformatf("row%0d collide", i), collide, tbl[i].ecol);
      check($sformatf("row%0d forward", i), {a_n, b_n, valid_n, drain_n},
            {tbl[i].a1, tbl[i].a0, tbl[i].b, tbl[i].valid, tbl[i].drain});
    end

    // Reset in the middle of an accumulation
    mode = 1; valid = 1; cv = 0; drain = 0; a[0] = 4; a[1] = 4; b = 4; c = '0;
    tick();
    tick();
    rst = 1; drain = 1; cv = 1; c[0] = 7; c[1] = 7;
    tick();
    check("mid-acc reset outputs", {c_ab, c_valid, a_n, b_n, valid_n, drain_n, collide}, 128'd0);
    rst = 0; valid = 0; cv = 0; drain = 1;
    tick();
    check("post-reset drain c_ab", c_ab, 128'd0);
    check("post-reset drain c_valid", c_valid, 1'b1);

    // Signed, narrow accumulator
    s_mode = 0; s_valid = 1; s_a[0] = 8'hfd; s_a[1] = 8'h03; s_b = 8'h04; s_c = '0;
    tick();
    check("signed pass neg", s_c_ab, {16'h000c, 16'hfff4});
    check("signed pass valid", s_c_valid, 1'b1);
    s_a[0] = 8'hfd; s_a[1] = 8'hfd; s_b = 8'hfd; s_c[0] = 16'h0010; s_c[1] = 16'hffff;
    tick();
    check("signed pass neg*neg", s_c_ab, {16'h0008, 16'h0019});
    s_mode = 1; s_a[0] = 8'h7f; s_a[1] = 8'h80; s_b = 8'h7f; s_c = '0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("signed accum beat%0d c_valid", k), s_c_valid, 1'b0);
    end
    s_valid = 0; s_drain = 1;
    tick();
    check("signed accum wrap", s_c_ab, {16'h4180, 16'hbd03});
    check("signed drain valid", s_c_valid, 1'b1);
    s_drain = 0;

    // Randomized run against the reference model
    for (int n = 0; n < 400; n++) begin
      rst   = (n == 0) || ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 9) == 0) mode = ~mode;
      valid = $urandom_range(0, 1) == 1;
      drain = $urandom_range(0, 6) == 0;
      cv    = $urandom_range(0, 4) == 0;
      for (int l = 0; l < V; l++) begin
        a[l] = 16'($urandom);
        c[l] = $urandom;
      end
      b = 16'($urandom);
      model_step();
      tick();
      check($sformatf("rand%0d c_ab", n), c_ab, {mc[1], mc[0]});
      check($sformatf("rand%0d c_valid", n), c_valid, mcv);
      check($sformatf("rand%0d collide", n), collide, mcol);
      check($sformatf("rand%0d forward", n), {a_n, b_n, valid_n, drain_n}, mfwd);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
